// File: rtl/lsu_bus_master_if.sv
// Data-memory bus between the load/store unit and its responder.
// The master drives the request side and the responder drives ready/read data.
interface lsu_bus_master_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_be,
    output bus_wdata,
    input  bus_ready,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_be,
    input  bus_wdata,
    output bus_ready,
    output bus_rdata
  );
endinterface

// File: rtl/lsu_bus_master.sv
// Load/store bus initiator: one CPU memory instruction becomes one word-aligned
// bus transaction. Stores get byte enables and lane-replicated data; loads get
// lane selection and sign/zero extension. Illegal accesses and bus stalls that
// exceed TIMEOUT_CYCLES finish with an error instead of a transfer.
module lsu_bus_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     is_store,
  input  logic [2:0]               funct3,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              rdata,
  output logic                     err_misalign,
  output logic                     err_timeout,
  lsu_bus_master_if.master         bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FIN  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // Counter wide enough to hold TIMEOUT_CYCLES-1; a 1-bit stub when disabled.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TO_ENABLE = (TIMEOUT_CYCLES != 0);

  state_t           state_r;
  logic             is_store_r;
  logic [2:0]       funct3_r;
  logic [1:0]       lane_r;
  logic [CNT_W-1:0] cnt_r;

  logic             legal_s;
  logic [3:0]       be_s;
  logic [31:0]      wdata_lane_s;

  // Access legality: alignment by size, known funct3, no unsigned stores.
  function automatic logic is_legal(input logic st, input logic [2:0] f3,
                                    input logic [1:0] lo);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b100:  ok = ~st;
      3'b001:  ok = ~lo[0];
      3'b101:  ok = ~lo[0] & ~st;
      3'b010:  ok = (lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Store byte enables for the addressed lane(s).
  function automatic logic [3:0] calc_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data replicated so every lane carries the right-justified operand.
  function automatic logic [31:0] calc_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{wd[7:0]}};
      2'b01:   w = {2{wd[15:0]}};
      2'b10:   w = wd;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Select the loaded lane and extend it according to funct3.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h00_0000, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0000, h};
      3'b010:  r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Decode the incoming request so it can be registered at start.
  always_comb begin
    legal_s      = is_legal(is_store, funct3, addr[1:0]);
    be_s         = 4'b0000;
    wdata_lane_s = 32'h0000_0000;
    if (is_store) begin
      be_s         = calc_be(funct3, addr[1:0]);
      wdata_lane_s = calc_wdata(funct3, wdata);
    end else begin
      be_s         = 4'b0000;
      wdata_lane_s = 32'h0000_0000;
    end
  end

  // Control FSM with all outputs registered; completion outputs default to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= S_IDLE;
      is_store_r    <= 1'b0;
      funct3_r      <= 3'b000;
      lane_r        <= 2'b00;
      cnt_r         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rdata         <= 32'h0000_0000;
      err_misalign  <= 1'b0;
      err_timeout   <= 1'b0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'h0000_0000;
      bus.bus_be    <= 4'b0000;
      bus.bus_wdata <= 32'h0000_0000;
    end else begin
      done         <= 1'b0;
      rdata        <= 32'h0000_0000;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            is_store_r <= is_store;
            funct3_r   <= funct3;
            lane_r     <= addr[1:0];
            busy       <= 1'b1;
            cnt_r      <= '0;
            if (legal_s) begin
              state_r       <= S_REQ;
              bus.bus_req   <= 1'b1;
              bus.bus_we    <= is_store;
              bus.bus_addr  <= {addr[31:2], 2'b00};
              bus.bus_be    <= be_s;
              bus.bus_wdata <= wdata_lane_s;
            end else begin
              state_r      <= S_ERR;
              done         <= 1'b1;
              err_misalign <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (bus.bus_ready) begin
            state_r <= S_FIN;
            done    <= 1'b1;
            rdata   <= is_store_r ? 32'h0000_0000
                                  : load_extend(funct3_r, lane_r, bus.bus_rdata);
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'h0000_0000;
            bus.bus_be    <= 4'b0000;
            bus.bus_wdata <= 32'h0000_0000;
          end else if (TO_ENABLE && (cnt_r == TO_LAST)) begin
            state_r       <= S_ERR;
            done          <= 1'b1;
            err_timeout   <= 1'b1;
            cnt_r         <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'h0000_0000;
            bus.bus_be    <= 4'b0000;
            bus.bus_wdata <= 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_FIN, S_ERR: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r       <= S_IDLE;
          busy          <= 1'b0;
          bus.bus_req   <= 1'b0;
          bus.bus_we    <= 1'b0;
          bus.bus_addr  <= 32'h0000_0000;
          bus.bus_be    <= 4'b0000;
          bus.bus_wdata <= 32'h0000_0000;
        end
      endcase
    end
  end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
- Multi-cycle load/store initiator that turns one CPU memory instruction into a single word-aligned bus transaction toward the data memory.
- Stores: generates byte enables and lane-replicated write data.
- Loads: selects the addressed byte/halfword lane and sign- or zero-extends it.
- Sits between the execute stage and the data-memory port. Reports misalignment and bus timeout instead of issuing bad accesses.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles bus_req may wait for bus_ready before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request pulse; sampled only in IDLE
- is_store  in  1  1=store, 0=load
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; BU/HU are illegal for stores
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result, valid while done=1
- err_misalign  out  1  valid with done
- err_timeout  out  1  valid with done
- bus_req  out  1  transaction request
- bus_we  out  1  write strobe
- bus_addr  out  32  {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-positioned write data
- bus_ready  in  1  responder accept/complete
- bus_rdata  in  32  read word, valid when bus_ready=1

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-transaction aborts immediately; no done pulse is produced.
- States: IDLE, REQ, FIN, ERR.
- IDLE:
  - start=1 latches is_store, funct3, addr and wdata.
  - Illegal access goes to ERR and no bus request is issued. Illegal means: H/HU with addr[0]=1; W with addr[1:0]≠00; funct3 not in {000,001,010,100,101}; store with funct3[2]=1.
  - Legal access goes to REQ.
- REQ:
  - bus_req=1 and busy=1. bus_we, bus_addr, bus_be and bus_wdata come from registers and stay stable until the handshake.
  - Handshake completes on a rising edge where bus_req=1 and bus_ready=1. On that edge, for loads, capture the extended bus_rdata into rdata; then go to FIN.
  - Timeout counter increments each REQ cycle without ready. When the count reaches TIMEOUT_CYCLES, go to ERR with err_timeout=1 and drop bus_req.
- FIN: done=1 for one cycle, rdata valid (0 for stores), then IDLE with busy=0.
- ERR: done=1 with err_misalign or err_timeout set for one cycle, rdata=0, then IDLE.
- Latency:
  - start at edge N puts bus_req high in cycle N+1.
  - With bus_ready tied high, done is high in cycle N+2.
  - A misaligned access pulses done in cycle N+1.
- start is ignored while busy or done is high; no queueing.
- Byte enables:
  - SB: 0001 << addr[1:0].
  - SH: 0011 when addr[1]=0, 1100 when addr[1]=1.
  - SW: 1111.
  - Loads: 0000, with bus_we=0.
- Store write data: SB = {4{wdata[7:0]}}, SH = {2{wdata[15:0]}}, SW = wdata.
- Load lane select: byte lane = addr[1:0], half lane = addr[1]. LB/LH sign-extend bit 7/15 of the selected lane; LBU/LHU zero-extend; LW passes the full word.
- done, err_* and rdata are registered outputs and are cleared in every cycle that is not FIN or ERR.

Test Plan:
- Store byte: SB, addr=0x00000013, wdata=0x000000A5, bus_ready high -> bus_addr=0x10, bus_be=1000, bus_wdata=0xA5A5A5A5, bus_we=1; done 2 cycles after start, no errors.
- Load byte: LB/LBU at addr=0x6, bus_rdata=0x12F0_3456 -> LB rdata=0xFFFFFFF0; LBU rdata=0x000000F0; LHU at 0x6 -> 0x000012F0.
- Misalignment: LW at addr=0x2, then SH at addr=0x5 -> bus_req never asserted; done+err_misalign in cycle N+1; rdata=0.
- Wait states: SW with bus_ready low 5 cycles, then high -> bus_req/bus_addr/bus_be stable all 6 REQ cycles; done one cycle after the ready edge.
- Timeout and reset: with TIMEOUT_CYCLES=16 and bus_ready held low -> done+err_timeout after 16 REQ cycles. Repeat, asserting reset in REQ cycle 3 -> all outputs 0 immediately, no done pulse; a new start after reset completes normally.
- Busy rejection: second start pulse during REQ -> ignored; exactly one bus handshake and one done pulse.
